// File: rtl/mem_stream_writer.sv
// Streams 16-bit words into consecutive PSRAM word addresses by driving the
// memory_interface 8-bit register port: address bytes, data bytes, write command, status polling.
module mem_stream_writer #(
    parameter int POLL_LIMIT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [22:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic [15:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_written,
    output logic             mi_cs,
    output logic             mi_write,
    output logic             mi_read,
    output logic [3:0]       mi_address,
    output logic [7:0]       mi_data_in,
    input  logic [7:0]       mi_data_out,
    output logic [3:0]       dbg_state
);

    localparam int PC_W = $clog2(POLL_LIMIT + 1);
    localparam logic [PC_W-1:0] POLL_MAX = PC_W'(POLL_LIMIT);

    typedef enum logic [3:0] {
        IDLE, WAIT_DATA, A0, A1, A2, D0, D1, CMD, POLL_REQ, POLL_CHK, NEXT, FIN
    } state_t;

    state_t           state, state_nx;
    logic [22:0]      cur_addr;
    logic [CNT_W-1:0] remaining;
    logic [15:0]      data_q;
    logic [PC_W-1:0]  poll_cnt;
    logic [3:0]       addr_hold, strobe_addr;
    logic [7:0]       wdata_hold, strobe_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            data_q        <= '0;
            poll_cnt      <= '0;
            words_written <= '0;
            error         <= 1'b0;
            addr_hold     <= '0;
            wdata_hold    <= '0;
        end else begin
            state <= state_nx;
            // The register bus keeps its last address/data between strobes.
            if (mi_write || mi_read) begin
                addr_hold  <= strobe_addr;
                wdata_hold <= strobe_data;
            end
            case (state)
                IDLE: begin
                    if (start && (word_count != '0)) begin
                        cur_addr      <= base_addr;
                        remaining     <= word_count;
                        words_written <= '0;
                        error         <= 1'b0;
                        poll_cnt      <= '0;
                    end
                end
                WAIT_DATA: if (s_valid) data_q <= s_data;
                POLL_REQ:  poll_cnt <= poll_cnt + 1'b1;
                POLL_CHK:  if (mi_data_out[0] && (poll_cnt == POLL_MAX)) error <= 1'b1;
                NEXT: begin
                    cur_addr      <= cur_addr + 23'd1;
                    words_written <= words_written + 1'b1;
                    remaining     <= remaining - 1'b1;
                    poll_cnt      <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        s_ready     = 1'b0;
        mi_write    = 1'b0;
        mi_read     = 1'b0;
        strobe_addr = addr_hold;
        strobe_data = wdata_hold;
        case (state)
            IDLE: if (start) state_nx = (word_count == '0) ? FIN : WAIT_DATA;
            WAIT_DATA: begin
                s_ready = 1'b1;
                if (s_valid) state_nx = A0;
            end
            A0: begin
                mi_write = 1'b1; strobe_addr = 4'd1; strobe_data = cur_addr[7:0];
                state_nx = A1;
            end
            A1: begin
                mi_write = 1'b1; strobe_addr = 4'd2; strobe_data = cur_addr[15:8];
                state_nx = A2;
            end
            A2: begin
                mi_write = 1'b1; strobe_addr = 4'd3; strobe_data = {1'b0, cur_addr[22:16]};
                state_nx = D0;
            end
            D0: begin
                mi_write = 1'b1; strobe_addr = 4'd4; strobe_data = data_q[7:0];
                state_nx = D1;
            end
            D1: begin
                mi_write = 1'b1; strobe_addr = 4'd5; strobe_data = data_q[15:8];
                state_nx = CMD;
            end
            CMD: begin
                mi_write = 1'b1; strobe_addr = 4'd9; strobe_data = 8'h00;
                state_nx = POLL_REQ;
            end
            POLL_REQ: begin
                mi_read = 1'b1; strobe_addr = 4'd10; strobe_data = 8'h00;
                state_nx = POLL_CHK;
            end
            // Status byte arrives the cycle after the read strobe; bit0 = memory busy.
            POLL_CHK: begin
                if (!mi_data_out[0])          state_nx = NEXT;
                else if (poll_cnt == POLL_MAX) state_nx = FIN;
                else                           state_nx = POLL_REQ;
            end
            NEXT:    state_nx = (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) ? FIN : WAIT_DATA;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mi_cs      = mi_write | mi_read;
    assign mi_address = strobe_addr;
    assign mi_data_in = strobe_data;
    assign busy       = (state != IDLE) && (state != FIN);
    assign done       = (state == FIN);
    assign dbg_state  = state;

endmodule

// File: tb/tb_mem_stream_writer.sv
// Bench for mem_stream_writer: register-bus scoreboard, status-register model,
// table of transfers plus hand-written reset/zero-count/start-while-busy sequences.
module tb_mem_stream_writer;

    localparam int PL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [22:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, busy, done, error;
    logic [15:0] words_written;
    logic        mi_cs, mi_write, mi_read;
    logic [3:0]  mi_address;
    logic [7:0]  mi_data_in;
    logic [7:0]  mi_data_out = '0;
    logic [3:0]  dbg_state;

    mem_stream_writer #(.POLL_LIMIT(PL), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .done(done), .error(error), .words_written(words_written),
        .mi_cs(mi_cs), .mi_write(mi_write), .mi_read(mi_read), .mi_address(mi_address),
        .mi_data_in(mi_data_in), .mi_data_out(mi_data_out), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Status register model: reports busy for polls_cfg reads after each write command.
    int polls_cfg = 0;
    int poll_idx = 0;
    always @(posedge clk) begin
        if (mi_write && mi_address == 4'd9) poll_idx <= 0;
        else if (mi_read) begin
            mi_data_out <= {7'b0, (poll_idx < polls_cfg)};
            poll_idx    <= poll_idx + 1;
        end
    end

    typedef struct {
        logic [22:0] base;
        logic [15:0] count;
        int          busy_polls;
        int          max_gap;
        bit          use_fixed;
        logic [15:0] fixed_data;
        logic        exp_err;
        logic [15:0] exp_words;
    } vec_t;

    logic [12:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            check("strobe_rules", {mi_cs, mi_write & mi_read, s_ready & (mi_write | mi_read | ~busy)},
                  {mi_write | mi_read, 1'b0, 1'b0});
            if (mi_write || mi_read) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %0h expected none", {mi_write, mi_address, mi_data_in});
                end else begin
                    e = exp_q.pop_front();
                    check("mi_strobe", {mi_write, mi_address, mi_data_in}, e);
                end
            end
        end
    endtask

    task automatic push_word(input logic [22:0] a, input logic [15:0] d, input int nreads);
        exp_q.push_back({1'b1, 4'd1, a[7:0]});
        exp_q.push_back({1'b1, 4'd2, a[15:8]});
        exp_q.push_back({1'b1, 4'd3, 1'b0, a[22:16]});
        exp_q.push_back({1'b1, 4'd4, d[7:0]});
        exp_q.push_back({1'b1, 4'd5, d[15:8]});
        exp_q.push_back({1'b1, 4'd9, 8'h00});
        for (int r = 0; r < nreads; r++) exp_q.push_back({1'b0, 4'd10, 8'h00});
    endtask

    task automatic pulse_start(input logic [22:0] b, input logic [15:0] c);
        @(posedge clk); #1;
        base_addr = b; word_count = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers one word and returns after the handshake edge (+1).
    task automatic send_word(input logic [15:0] d);
        bit got = 0;
        s_valid = 1'b1; s_data = d;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (s_ready) got = 1;
        end
        check("handshake_seen", got, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit poke_start);
        int done0 = done_cnt;
        bit abort = (v.busy_polls >= PL);
        int nsend = abort ? 1 : int'(v.count);
        int nreads = abort ? PL : v.busy_polls + 1;
        logic [22:0] a = v.base;
        logic [15:0] d;
        bit seen = 0;
        polls_cfg = v.busy_polls;
        pulse_start(v.base, v.count);
        for (int i = 0; i < nsend; i++) begin
            repeat ($urandom_range(v.max_gap, 0)) @(posedge clk);
            #1;
            d = v.use_fixed ? v.fixed_data : 16'($urandom);
            push_word(a, d, nreads);
            send_word(d);
            if (poke_start && i == 0) begin
                base_addr = 23'h0; word_count = 16'd7; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            a = a + 23'd1;
        end
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("done_seen", seen, 1'b1);
        check("error_at_done", error, v.exp_err);
        check("words_written", words_written, v.exp_words);
        check("busy_at_done", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt - done0, 1);
        check("error_sticky", error, v.exp_err);
        check("queue_drained", exp_q.size(), 0);
    endtask

    vec_t vecs[5];
    vec_t pv;

    initial begin
        int done0;
        bit hit;
        fork monitor(); join_none

        vecs[0] = '{23'h012345, 16'd1, 3,    0, 1'b1, 16'hAA55, 1'b0, 16'd1};
        vecs[1] = '{23'h7FFFFE, 16'd4, 0,    5, 1'b0, 16'h0000, 1'b0, 16'd4};
        vecs[2] = '{23'h000040, 16'd2, 1000, 2, 1'b0, 16'h0000, 1'b1, 16'd0};
        vecs[3] = '{23'h000100, 16'd1, 1,    0, 1'b0, 16'h0000, 1'b0, 16'd1};
        vecs[4] = '{23'h3ABCDE, 16'd3, 2,    3, 1'b0, 16'h0000, 1'b0, 16'd3};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {busy, done, error, s_ready, mi_cs, mi_write, mi_read,
                                mi_address, mi_data_in, words_written}, 35'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

        // Start pulsed while busy must not disturb the latched base or count.
        pv = '{23'h000300, 16'd2, 2, 1, 1'b0, 16'h0000, 1'b0, 16'd2};
        run_vec(pv, 1'b1);

        // Zero-length transfer: done the next cycle, never busy, no bus traffic.
        done0 = done_cnt;
        pulse_start(23'h000050, 16'd0);
        @(negedge clk);
        check("zero_done", {done, busy}, 2'b10);
        @(negedge clk);
        check("zero_done_clears", {done, busy}, 2'b00);
        check("zero_done_pulses", done_cnt - done0, 1);

        // Reset during a status read aborts silently.
        polls_cfg = 1000;
        done0 = done_cnt;
        pulse_start(23'h000400, 16'd3);
        push_word(23'h000400, 16'h1234, 1);
        send_word(16'h1234);
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (mi_read) hit = 1;
        end
        check("poll_req_reached", hit, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_outputs", {busy, done, error, s_ready, mi_cs, mi_write, mi_read,
                                    mi_address, mi_data_in, words_written, dbg_state}, 39'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_no_done", done_cnt - done0, 0);
        check("reset_idle_busy", busy, 1'b0);
        check("reset_queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
